// File: rtl/uart_rx_param_pkg.sv
// rtl/uart_rx_param_pkg.sv - shared constants, FSM encoding and divider helper for the UART receiver
package uart_rx_param_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Clocks per oversample tick, never below one so tiny ratios still run.
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    int d;
    d = clk_hz / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_param_baud_tick.sv
// rtl/uart_rx_param_baud_tick.sv - free-running oversample tick generator
module uart_rx_param_baud_tick
  import uart_rx_param_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - oversampled UART receiver with parity/stop checking and show-ahead FIFO
module uart_rx_param
  import uart_rx_param_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int DEPTH      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int SW   = $clog2(OVERSAMPLE);
  localparam int BW   = $clog2(DATA_BITS);
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_END  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic                 rx_m, rx_s, tick;
  state_t               state, state_nxt;
  logic [SW-1:0]        scnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;
  logic                 mid_start, bit_end, complete, push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  uart_rx_param_baud_tick #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign mid_start = tick && (scnt == S_MID);
  assign bit_end   = tick && (scnt == S_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (tick && !rx_s) state_nxt = ST_START;
      ST_START:  if (mid_start) state_nxt = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:   if (bit_end && (bit_idx == B_LAST))
                   state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_end) state_nxt = ST_STOP;
      ST_STOP:   if (bit_end) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // A bad stop bit outranks a parity mismatch, so at most one pulse per frame.
  always_comb begin
    complete   = (state == ST_STOP) && bit_end;
    frame_err  = complete && !rx_s;
    parity_err = complete && rx_s && par_bad;
    push       = complete && rx_s && !par_bad;
  end

  // Sample phase counter, LSB-first shifter and parity verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
    end else if (tick) begin
      case (state)
        ST_IDLE: begin
          scnt    <= '0;
          bit_idx <= '0;
          par_bad <= 1'b0;
        end
        ST_START: scnt <= mid_start ? '0 : scnt + 1'b1;
        default: begin
          scnt <= bit_end ? '0 : scnt + 1'b1;
          if (bit_end && (state == ST_DATA)) begin
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
          end
          if (bit_end && (state == ST_PARITY))
            par_bad <= ((^shreg) ^ rx_s) != (PARITY == PAR_ODD);
        end
      endcase
    end
  end

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CNTW-1:0]      count;
  logic                 full, pop, wr_en;

  assign full    = (count == CNTW'(DEPTH));
  assign pop     = rx_valid && rx_ready;
  assign wr_en   = push && (!full || pop);
  assign overrun = push && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNTW'(wr_en) - CNTW'(pop);
    end
  end

  assign rx_valid = (count != '0);
  assign rx_data  = mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed bench for uart_rx_param (8N1 and 8E1 instances)
module tb_uart_rx_param;

  localparam int BIT = 160;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_a, rx_b, ready_a, ready_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, fe_a, fe_b, pe_a, pe_b, ov_a, ov_b;

  int checks = 0;
  int errors = 0;
  int n_fe_a = 0, n_pe_a = 0, n_ov_a = 0, n_fe_b = 0, n_pe_b = 0, n_ov_b = 0;

  always #5 clk = ~clk;

  uart_rx_param #(.CLK_HZ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(0), .DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_a), .rx_data(data_a), .rx_valid(valid_a),
    .rx_ready(ready_a), .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a));

  uart_rx_param #(.CLK_HZ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(2), .DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_b), .rx_data(data_b), .rx_valid(valid_b),
    .rx_ready(ready_b), .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b));

  always @(negedge clk) begin
    if (fe_a) n_fe_a++;
    if (pe_a) n_pe_a++;
    if (ov_a) n_ov_a++;
    if (fe_b) n_fe_b++;
    if (pe_b) n_pe_b++;
    if (ov_b) n_ov_b++;
  end

  typedef struct {
    bit         sel;
    logic [7:0] d;
    bit         p;
    bit         stop;
    bit         ev;
    logic [7:0] ed;
    int         efe;
    int         epe;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit use_par,
                            input bit p, input bit stop);
    drive(sel, 1'b0);
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive(sel, d[i]);
      repeat (BIT) @(negedge clk);
    end
    if (use_par) begin
      drive(sel, p);
      repeat (BIT) @(negedge clk);
    end
    drive(sel, stop);
    repeat (BIT) @(negedge clk);
    drive(sel, 1'b1);
  endtask

  task automatic pop_one(input bit sel);
    if (sel) ready_b = 1'b1;
    else     ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;
    ready_b = 1'b0;
  endtask

  initial begin
    int fe0, pe0, ov0;
    logic [7:0] partial;

    tbl[0] = '{0, 8'hA5, 0, 1, 1, 8'hA5, 0, 0};
    tbl[1] = '{0, 8'h3C, 0, 0, 0, 8'h00, 1, 0};
    tbl[2] = '{0, 8'h00, 0, 1, 1, 8'h00, 0, 0};
    tbl[3] = '{0, 8'hFF, 0, 1, 1, 8'hFF, 0, 0};
    tbl[4] = '{1, 8'h03, 1, 1, 0, 8'h00, 0, 1};
    tbl[5] = '{1, 8'h03, 0, 1, 1, 8'h03, 0, 0};
    tbl[6] = '{1, 8'h07, 1, 1, 1, 8'h07, 0, 0};
    tbl[7] = '{1, 8'h07, 0, 0, 0, 8'h00, 1, 0};

    rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b0; ready_b = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_valid_a", {31'd0, valid_a}, 0);
    check("reset_data_a", {24'd0, data_a}, 0);
    check("reset_pulses_a", {29'd0, fe_a, pe_a, ov_a}, 0);
    check("reset_valid_b", {31'd0, valid_b}, 0);
    check("reset_data_b", {24'd0, data_b}, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Short low glitch must be rejected at mid start bit.
    fe0 = n_fe_a; pe0 = n_pe_a;
    rx_a = 1'b0;
    repeat (64) @(negedge clk);
    rx_a = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_valid", {31'd0, valid_a}, 0);
    check("glitch_fe", n_fe_a - fe0, 0);
    check("glitch_pe", n_pe_a - pe0, 0);

    for (int r = 0; r < 8; r++) begin
      fe0 = tbl[r].sel ? n_fe_b : n_fe_a;
      pe0 = tbl[r].sel ? n_pe_b : n_pe_a;
      send_frame(tbl[r].sel, tbl[r].d, tbl[r].sel, tbl[r].p, tbl[r].stop);
      repeat (40) @(negedge clk);
      check($sformatf("row%0d_valid", r), {31'd0, tbl[r].sel ? valid_b : valid_a}, {31'd0, tbl[r].ev});
      if (tbl[r].ev)
        check($sformatf("row%0d_data", r), {24'd0, tbl[r].sel ? data_b : data_a}, {24'd0, tbl[r].ed});
      check($sformatf("row%0d_frame_err", r), (tbl[r].sel ? n_fe_b : n_fe_a) - fe0, tbl[r].efe);
      check($sformatf("row%0d_parity_err", r), (tbl[r].sel ? n_pe_b : n_pe_a) - pe0, tbl[r].epe);
      if (tbl[r].ev) begin
        pop_one(tbl[r].sel);
        check($sformatf("row%0d_pop_empty", r), {31'd0, tbl[r].sel ? valid_b : valid_a}, 0);
      end
    end

    // Five back-to-back frames into a 4-deep FIFO with no consumer.
    ov0 = n_ov_a;
    for (int k = 1; k <= 5; k++) send_frame(0, 8'(k), 0, 0, 1);
    repeat (40) @(negedge clk);
    check("ovr_pulses", n_ov_a - ov0, 1);
    check("ovr_valid", {31'd0, valid_a}, 1);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("drain%0d", k), {24'd0, data_a}, k);
      pop_one(0);
    end
    check("drain_empty", {31'd0, valid_a}, 0);

    // Reset in the middle of a frame with a word already queued.
    send_frame(0, 8'h11, 0, 0, 1);
    repeat (40) @(negedge clk);
    check("pre_reset_valid", {31'd0, valid_a}, 1);
    partial = 8'h5A;
    rx_a = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx_a = partial[i];
      repeat (BIT) @(negedge clk);
    end
    rst_n = 1'b0;
    rx_a = 1'b1;
    repeat (5) @(negedge clk);
    check("midreset_valid", {31'd0, valid_a}, 0);
    check("midreset_data", {24'd0, data_a}, 0);
    fe0 = n_fe_a;
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    send_frame(0, 8'h5A, 0, 0, 1);
    repeat (40) @(negedge clk);
    check("after_reset_valid", {31'd0, valid_a}, 1);
    check("after_reset_data", {24'd0, data_a}, 32'h5A);
    check("after_reset_fe", n_fe_a - fe0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
